// File: rtl/key_expansion_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : key_expansion_engine_if
// Description : Key-load and round-key read bundle for key_expansion_engine.
//               The master side issues start/key/reads; the slave side is the
//               key expansion engine itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_expansion_engine_if;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic         busy;
  logic         done;
  logic         err;
  logic         keys_valid;
  logic         rd_en;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;
  logic         rd_valid;

  modport master (
    output start, key_len, key, rd_en, rd_round,
    input  busy, done, err, keys_valid, rd_key, rd_valid
  );

  modport slave (
    input  start, key_len, key, rd_en, rd_round,
    output busy, done, err, keys_valid, rd_key, rd_valid
  );
endinterface
`default_nettype wire

// File: rtl/key_expansion_engine.sv
`default_nettype none
// ============================================================================
// Module      : key_expansion_engine
// Description : Iterative AES key expansion (128/192/256-bit keys), one 32-bit
//               schedule word per cycle into an internal word buffer, with a
//               pipelined 128-bit round-key read port.
//               Optional feature macro: KEYEXP_AES256_EN enables AES-256
//               (60-word buffer and the i mod 8 == 4 SubWord path); without
//               it the buffer is 52 words and key_len 2'b10 is rejected.
// Revision    : 1.0 - initial release
// ============================================================================
module key_expansion_engine #(
  parameter int RD_REG_OUT = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  key_expansion_engine_if.slave  kx_if
);

`ifdef KEYEXP_AES256_EN
  localparam int DEPTH = 60;
`else
  localparam int DEPTH = 52;
`endif

  // AES forward S-box, entry 0 leftmost
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_EXPAND = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     nk_q, nk_d;
  logic [3:0]     nr_q, nr_d;
  logic [5:0]     last_q, last_d;
  logic [255:0]   key_q, key_d;
  logic [5:0]     i_q, i_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [7:0]     rcon_q, rcon_d;
  logic           kv_q, kv_d;
  logic           err_q, err_d;

  logic [31:0]    buf_q [DEPTH];

  logic           len_legal;
  logic [3:0]     len_nk;
  logic [3:0]     len_nr;
  logic [5:0]     len_last;

  logic [5:0]     idx_prev;
  logic [5:0]     idx_back;
  logic [31:0]    w_prev;
  logic [31:0]    w_back;
  logic [31:0]    rot_w;
  logic [31:0]    sub_in;
  logic [31:0]    sub_out;
  logic [31:0]    t_word;
  logic [31:0]    w_new;
  logic [7:0]     rcon_next;

  logic           rd_ok;
  logic [5:0]     rd_base;
  logic [127:0]   rd_word;
  logic           rd_v1_q;
  logic [127:0]   rd_k1_q;

  // Decode key_len into Nk, Nr and the index of the last schedule word
  always_comb begin
    len_legal = 1'b0;
    len_nk    = 4'd4;
    len_nr    = 4'd10;
    len_last  = 6'd43;
    case (kx_if.key_len)
      2'b00: begin
        len_legal = 1'b1;
      end
      2'b01: begin
        len_legal = 1'b1;
        len_nk    = 4'd6;
        len_nr    = 4'd12;
        len_last  = 6'd51;
      end
`ifdef KEYEXP_AES256_EN
      2'b10: begin
        len_legal = 1'b1;
        len_nk    = 4'd8;
        len_nr    = 4'd14;
        len_last  = 6'd59;
      end
`endif
      default: len_legal = 1'b0;
    endcase
  end

  assign idx_prev  = i_q - 6'd1;
  assign idx_back  = i_q - {2'b00, nk_q};
  assign w_prev    = buf_q[idx_prev];
  assign w_back    = buf_q[idx_back];
  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  // New schedule word: one shared 4-byte S-box stage feeds both SubWord cases
  always_comb begin
    rot_w   = {w_prev[23:0], w_prev[31:24]};
    sub_in  = (cnt_q == 3'd0) ? rot_w : w_prev;
    sub_out = sub_word(sub_in);
    t_word  = w_prev;
    if (cnt_q == 3'd0) begin
      t_word = sub_out ^ {rcon_q, 24'h000000};
    end
`ifdef KEYEXP_AES256_EN
    else if ((nk_q == 4'd8) && (cnt_q == 3'd4)) begin
      t_word = sub_out;
    end
`endif
    w_new = w_back ^ t_word;
  end

  // Next-state and control-register update for the expansion sequence
  always_comb begin
    state_d = state_q;
    nk_d    = nk_q;
    nr_d    = nr_q;
    last_d  = last_q;
    key_d   = key_q;
    i_d     = i_q;
    cnt_d   = cnt_q;
    rcon_d  = rcon_q;
    kv_d    = kv_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (kx_if.start) begin
          if (len_legal) begin
            nk_d    = len_nk;
            nr_d    = len_nr;
            last_d  = len_last;
            key_d   = kx_if.key;
            kv_d    = 1'b0;
            state_d = S_LOAD;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      S_LOAD: begin
        i_d     = {2'b00, nk_q};
        cnt_d   = 3'd0;
        rcon_d  = 8'h01;
        state_d = S_EXPAND;
      end
      S_EXPAND: begin
        i_d   = i_q + 6'd1;
        cnt_d = ({1'b0, cnt_q} == (nk_q - 4'd1)) ? 3'd0 : (cnt_q + 3'd1);
        if (cnt_q == 3'd0) begin
          rcon_d = rcon_next;
        end
        if (i_q == last_q) begin
          kv_d    = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Expansion control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nk_q   <= 4'd4;
      nr_q   <= 4'd0;
      last_q <= 6'd43;
      key_q  <= '0;
      i_q    <= 6'd0;
      cnt_q  <= 3'd0;
      rcon_q <= 8'h01;
      kv_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      nk_q   <= nk_d;
      nr_q   <= nr_d;
      last_q <= last_d;
      key_q  <= key_d;
      i_q    <= i_d;
      cnt_q  <= cnt_d;
      rcon_q <= rcon_d;
      kv_q   <= kv_d;
      err_q  <= err_d;
    end
  end

  // Schedule buffer: LOAD copies the key words, EXPAND appends one word
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD) begin
      for (int k = 0; k < 8; k++) begin
        if (k < int'(nk_q)) begin
          buf_q[k] <= key_q[255 - 32*k -: 32];
        end
      end
    end else if (state_q == S_EXPAND) begin
      buf_q[i_q] <= w_new;
    end
  end

  assign rd_ok   = kx_if.rd_en && kv_q && (kx_if.rd_round <= nr_q);
  assign rd_base = {kx_if.rd_round, 2'b00};
  assign rd_word = {buf_q[rd_base], buf_q[rd_base | 6'd1],
                    buf_q[rd_base | 6'd2], buf_q[rd_base | 6'd3]};

  // First read stage; rd_key holds its value when no read is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1_q <= 1'b0;
      rd_k1_q <= '0;
    end else begin
      rd_v1_q <= rd_ok;
      if (rd_ok) begin
        rd_k1_q <= rd_word;
      end
    end
  end

  generate
    if (RD_REG_OUT != 0) begin : g_rd_reg
      logic         rd_v2_q;
      logic [127:0] rd_k2_q;

      // Optional second read stage for timing closure on the output path
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_v2_q <= 1'b0;
          rd_k2_q <= '0;
        end else begin
          rd_v2_q <= rd_v1_q;
          if (rd_v1_q) begin
            rd_k2_q <= rd_k1_q;
          end
        end
      end

      assign kx_if.rd_valid = rd_v2_q;
      assign kx_if.rd_key   = rd_k2_q;
    end else begin : g_rd_direct
      assign kx_if.rd_valid = rd_v1_q;
      assign kx_if.rd_key   = rd_k1_q;
    end
  endgenerate

  assign kx_if.busy       = (state_q == S_LOAD) || (state_q == S_EXPAND);
  assign kx_if.done       = (state_q == S_EXPAND) && (i_q == last_q);
  assign kx_if.err        = err_q;
  assign kx_if.keys_valid = kv_q;

endmodule
`default_nettype wire

// File: tb/tb_key_expansion_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_expansion_engine
// Description : Self-checking bench for key_expansion_engine. Two instances
//               (RD_REG_OUT 0 and 1) share stimulus and are compared every
//               cycle against a schedule model computed from GF(2^8) math.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_expansion_engine;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  key_expansion_engine_if if0 ();
  key_expansion_engine_if if1 ();

  assign if1.start    = if0.start;
  assign if1.key_len  = if0.key_len;
  assign if1.key      = if0.key;
  assign if1.rd_en    = if0.rd_en;
  assign if1.rd_round = if0.rd_round;

  key_expansion_engine #(.RD_REG_OUT(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .kx_if(if0));
  key_expansion_engine #(.RD_REG_OUT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .kx_if(if1));

`ifdef KEYEXP_AES256_EN
  localparam bit LEGAL256 = 1'b1;
`else
  localparam bit LEGAL256 = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  logic [31:0]  m_sched [60];
  logic [31:0]  m_pend  [60];
  bit           m_active;
  int           m_rem;
  bit           m_kv;
  bit           m_err;
  int           m_nr;
  bit           m_v0, m_v1;
  logic [127:0] m_k0, m_k1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] p, r, s;
    p = gmul(x, x);
    r = p;
    for (int n = 2; n < 8; n++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon_of(input int j);
    logic [7:0] r = 8'h01;
    for (int q = 1; q < j; q++) r = gmul(r, 8'h02);
    return r;
  endfunction

  task automatic build_schedule(input logic [255:0] k, input int nk, input int nr);
    logic [31:0] t;
    for (int i = 0; i < nk; i++) m_pend[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = m_pend[i-1];
      if (i % nk == 0)
        t = subw({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
      else if (nk > 6 && i % nk == 4)
        t = subw(t);
      m_pend[i] = m_pend[i-nk] ^ t;
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_rem = 0; m_kv = 0; m_err = 0; m_nr = 0;
    m_v0 = 0; m_v1 = 0; m_k0 = '0; m_k1 = '0;
  endtask

  // Advance the model by one rising edge using the inputs sampled there
  task automatic model_edge();
    bit acc, pv, legal;
    logic [127:0] pk;
    int r, nk, nr;
    if (!rst_n) begin
      model_reset();
      return;
    end
    r   = int'(if0.rd_round);
    acc = if0.rd_en && m_kv && (r <= m_nr);
    pv  = m_v0;
    pk  = m_k0;
    m_v1 = pv;
    if (pv) m_k1 = pk;
    m_v0 = acc;
    if (acc) m_k0 = {m_sched[4*r], m_sched[4*r+1], m_sched[4*r+2], m_sched[4*r+3]};
    m_err = 0;
    if (m_active) begin
      m_rem--;
      if (m_rem == 0) begin
        m_active = 0;
        m_kv = 1;
        for (int i = 0; i < 60; i++) m_sched[i] = m_pend[i];
      end
    end else if (if0.start) begin
      legal = 1;
      nk = 4; nr = 10;
      case (if0.key_len)
        2'b00: begin nk = 4; nr = 10; end
        2'b01: begin nk = 6; nr = 12; end
        2'b10: begin nk = 8; nr = 14; legal = LEGAL256; end
        default: legal = 0;
      endcase
      if (legal) begin
        m_active = 1;
        m_rem    = 1 + (4 * (nr + 1) - nk);
        m_kv     = 0;
        m_nr     = nr;
        build_schedule(if0.key, nk, nr);
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare both instances against the model
  task automatic check_outputs();
    chk("busy0",  if0.busy,       m_active);
    chk("busy1",  if1.busy,       m_active);
    chk("done0",  if0.done,       m_active && m_rem == 1);
    chk("done1",  if1.done,       m_active && m_rem == 1);
    chk("err0",   if0.err,        m_err);
    chk("err1",   if1.err,        m_err);
    chk("kv0",    if0.keys_valid, m_kv);
    chk("kv1",    if1.keys_valid, m_kv);
    chk("rdv0",   if0.rd_valid,   m_v0);
    chk("rdv1",   if1.rd_valid,   m_v1);
    chk("rdkey0", if0.rd_key,     m_k0);
    chk("rdkey1", if1.rd_key,     m_k1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  // Start an expansion and measure cycles from start to the done pulse
  task automatic run_expand(input logic [255:0] k, input logic [1:0] len,
                            input int lat, input string name, input bit noise);
    int n = 0;
    if0.key     = k;
    if0.key_len = len;
    if0.start   = 1'b1;
    do begin
      tick();
      n++;
      if0.start = noise && (n % 5 == 0);
      if (noise) if0.key_len = 2'($urandom_range(0, 3));
    end while (!if0.done && n < 200);
    if0.start = 1'b0;
    chk(name, n, lat);
    tick();
  endtask

  task automatic read_rounds(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      if0.rd_en    = 1'b1;
      if0.rd_round = 4'(r);
      tick();
    end
    if0.rd_en = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] rk;
    if0.start = 0; if0.key_len = 0; if0.key = '0; if0.rd_en = 0; if0.rd_round = 0;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // AES-128 known-answer
    run_expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 2'b00, 41, "lat128", 0);
    chk("model_r1",  {m_sched[4], m_sched[5], m_sched[6], m_sched[7]},
        128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_r10", {m_sched[40], m_sched[41], m_sched[42], m_sched[43]},
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    if0.rd_en = 1'b1; if0.rd_round = 4'd1;
    tick();
    chk("dut0_r1_lit", if0.rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
    if0.rd_round = 4'd10;
    tick();
    chk("dut1_r1_lit", if1.rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
    chk("dut0_r10_lit", if0.rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    if0.rd_round = 4'd11;
    tick();
    chk("oob_rdv0", if0.rd_valid, 1'b0);
    if0.rd_en = 1'b0;
    tick();
    read_rounds(0, 10);

    // Illegal key_len in DONE
    if0.key_len = 2'b11; if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    chk("ill_err", if0.err, 1'b1);
    chk("ill_kv",  if0.keys_valid, 1'b1);
    tick();

    // AES-192
    run_expand({192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 2'b01, 47, "lat192", 0);
    chk("model_w51", m_sched[51], 32'h01002202);
    read_rounds(0, 13);

    // AES-256
`ifdef KEYEXP_AES256_EN
    run_expand(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
               2'b10, 53, "lat256", 0);
    chk("model_w59", m_sched[59], 32'h706c631e);
    read_rounds(0, 15);
`else
    build_schedule(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 8, 14);
    chk("model_w59", m_pend[59], 32'h706c631e);
    if0.key = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    if0.key_len = 2'b10; if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    chk("aes256_err",  if0.err,  1'b1);
    chk("aes256_busy", if0.busy, 1'b0);
    tick();
    chk("aes256_busy2", if0.busy, 1'b0);
    read_rounds(12, 15);
`endif

    // Reset in the middle of EXPAND
    if0.key = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    if0.key_len = 2'b00; if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_busy", if0.busy, 1'b0);
    chk("rst_done", if0.done, 1'b0);
    chk("rst_kv",   if0.keys_valid, 1'b0);
    chk("rst_key1", if1.rd_key, 128'h0);
    check_outputs();
    tick();
    rst_n = 1'b1;
    tick();

    // Re-start with start pulses while busy
    run_expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 2'b00, 41, "lat128_re", 1);
    read_rounds(0, 10);

    // Start issued while reads stream in DONE
    if0.rd_en = 1'b1; if0.rd_round = 4'd3;
    tick();
    if0.key = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    if0.key_len = 2'b01; if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    chk("kv_drop", if0.keys_valid, 1'b0);
    if0.rd_en = 1'b0;
    repeat (60) tick();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int j = 0; j < 8; j++) rk[j*32 +: 32] = $urandom();
      if0.key      = rk;
      if0.start    = ($urandom_range(0, 29) == 0);
      if0.key_len  = 2'($urandom_range(0, 3));
      if0.rd_en    = 1'($urandom_range(0, 1));
      if0.rd_round = 4'($urandom_range(0, 15));
      tick();
    end
    if0.start = 1'b0; if0.rd_en = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
